// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write arbiter with burst locking in front of one FIFO write port
// Requesters are granted round-robin; a winner keeps the port for up to BURST_LEN beats.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic                           fifo_full,
  output logic                           fifo_w_en,
  output logic [DATA_WIDTH-1:0]          fifo_data_in,
  output logic [(NUM_REQ > 1 ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
  output logic                           locked,
  output logic [15:0]                    write_count
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_last_grant;
  logic [3:0]      r_burst_cnt;
  logic [15:0]     r_write_count;

  logic [IW-1:0]      w_win;
  logic               w_found;
  logic [IW-1:0]      w_grant;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_burst_done;
  logic               w_w_en;

  // Rotating search starting one past the previous grant.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(r_last_grant) + k) % NUM_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_win   = IW'(idx);
      end
    end
  end

  assign w_burst_done = ((5'(r_burst_cnt) + 5'd1) == 5'(BURST_LEN));

  always_comb begin
    w_next_state = r_state;
    w_ready      = '0;
    w_grant      = '0;
    case (r_state)
      ST_IDLE: begin
        if (!fifo_full && w_found) begin
          w_ready[w_win] = 1'b1;
          w_grant        = w_win;
          w_next_state   = (BURST_LEN > 1) ? ST_LOCKED : ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (req_valid[r_owner]) begin
          if (!fifo_full) begin
            w_ready[r_owner] = 1'b1;
            w_grant          = r_owner;
            if (w_burst_done) begin
              w_next_state = ST_IDLE;
            end
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
    // Outputs are forced quiet during reset even though state is already IDLE.
    if (!rst_n) begin
      w_ready = '0;
      w_grant = '0;
    end
  end

  assign w_w_en       = |(req_valid & w_ready);
  assign req_ready    = w_ready;
  assign fifo_w_en    = w_w_en;
  assign grant_id     = w_w_en ? w_grant : '0;
  assign fifo_data_in = w_w_en ? req_data[int'(w_grant)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign locked       = (r_state == ST_LOCKED);
  assign write_count  = r_write_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_owner       <= '0;
      r_last_grant  <= IW'(NUM_REQ - 1);
      r_burst_cnt   <= 4'd0;
      r_write_count <= 16'd0;
    end else begin
      r_state <= w_next_state;
      if (w_w_en) begin
        r_write_count <= r_write_count + 16'd1;
        if (r_state == ST_IDLE) begin
          r_last_grant <= w_win;
          r_owner      <= w_win;
          r_burst_cnt  <= 4'd1;
        end else begin
          r_burst_cnt  <= r_burst_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_w_en;
  logic [7:0]  fifo_data_in;
  logic [1:0]  grant_id;
  logic        locked;
  logic [15:0] write_count;

  int checks;
  int failures;
  int onehot_bad;

  fifo_wr_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .BURST_LEN(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_w_en(fifo_w_en),
    .fifo_data_in(fifo_data_in), .grant_id(grant_id), .locked(locked),
    .write_count(write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ($countones(req_ready) > 1) onehot_bad++;
  end

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'b1111; req_data = 32'hA3A2A1A0; fifo_full = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 4'b0000 || fifo_w_en !== 1'b0 || fifo_data_in !== 8'h00 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b w_en=%b data=%h grant=%0d, required 0000 0 00 0",
               req_ready, fifo_w_en, fifo_data_in, grant_id);
    end
    checks++;
    if (locked !== 1'b0 || write_count !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: locked=%b count=%0d, required 0 0", locked, write_count);
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int errs;
    errs = 0;
    rst_n = 1'b1;
    for (int b = 0; b < 16; b++) begin
      #1;
      checks++;
      if (fifo_w_en !== 1'b1 || grant_id !== 2'(b / 4) || fifo_data_in !== 8'(8'hA0 + b / 4) ||
          req_ready !== 4'(1 << (b / 4)) || locked !== ((b % 4) != 0)) begin
        failures++;
        $display("FAIL rr_beat%0d: w_en=%b grant=%0d data=%h ready=%b locked=%b, required 1 %0d %h %b %b",
                 b, fifo_w_en, grant_id, fifo_data_in, req_ready, locked, b / 4,
                 8'(8'hA0 + b / 4), 4'(1 << (b / 4)), (b % 4) != 0);
      end
      next_cycle();
    end
    req_valid = 4'b0000;
    #1;
    checks++;
    if (write_count !== 16'd16 || fifo_w_en !== 1'b0) begin
      failures++;
      $display("FAIL rr_count: count=%0d w_en=%b, required 16 0", write_count, fifo_w_en);
    end
    next_cycle();
  endtask

  task automatic test_single_requester();
    req_valid = 4'b0100;
    for (int b = 0; b < 5; b++) begin
      #1;
      checks++;
      if (fifo_w_en !== 1'b1 || grant_id !== 2'd2 || fifo_data_in !== 8'hA2 || locked !== (b != 0 && b != 4)) begin
        failures++;
        $display("FAIL single_beat%0d: w_en=%b grant=%0d data=%h locked=%b, required 1 2 a2 %b",
                 b, fifo_w_en, grant_id, fifo_data_in, locked, (b != 0 && b != 4));
      end
      next_cycle();
    end
    req_valid = 4'b0000;
    #1;
    checks++;
    if (fifo_w_en !== 1'b0 || locked !== 1'b1) begin
      failures++;
      $display("FAIL single_bubble: w_en=%b locked=%b, required 0 1", fifo_w_en, locked);
    end
    next_cycle();
    #1;
    checks++;
    if (locked !== 1'b0 || write_count !== 16'd21) begin
      failures++;
      $display("FAIL single_idle: locked=%b count=%0d, required 0 21", locked, write_count);
    end
    next_cycle();
  endtask

  task automatic test_full_stall();
    req_valid = 4'b0010;
    for (int b = 0; b < 2; b++) begin
      #1;
      checks++;
      if (fifo_w_en !== 1'b1 || grant_id !== 2'd1 || locked !== (b == 1)) begin
        failures++;
        $display("FAIL stall_pre%0d: w_en=%b grant=%0d locked=%b, required 1 1 %b",
                 b, fifo_w_en, grant_id, locked, b == 1);
      end
      next_cycle();
    end
    fifo_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      checks++;
      if (fifo_w_en !== 1'b0 || req_ready !== 4'b0000 || locked !== 1'b1) begin
        failures++;
        $display("FAIL stall_full%0d: w_en=%b ready=%b locked=%b, required 0 0000 1",
                 s, fifo_w_en, req_ready, locked);
      end
      next_cycle();
    end
    fifo_full = 1'b0;
    for (int b = 0; b < 2; b++) begin
      #1;
      checks++;
      if (fifo_w_en !== 1'b1 || grant_id !== 2'd1 || fifo_data_in !== 8'hA1 || locked !== 1'b1) begin
        failures++;
        $display("FAIL stall_post%0d: w_en=%b grant=%0d data=%h locked=%b, required 1 1 a1 1",
                 b, fifo_w_en, grant_id, fifo_data_in, locked);
      end
      next_cycle();
    end
    req_valid = 4'b0000;
    #1;
    checks++;
    if (locked !== 1'b0 || write_count !== 16'd25) begin
      failures++;
      $display("FAIL stall_end: locked=%b count=%0d, required 0 25", locked, write_count);
    end
  endtask

  task automatic test_owner_drop();
    req_valid = 4'b0001;
    #1;
    checks++;
    if (fifo_w_en !== 1'b1 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL drop_beat1: w_en=%b grant=%0d, required 1 0", fifo_w_en, grant_id);
    end
    next_cycle();
    req_valid = 4'b1001;
    #1;
    checks++;
    if (fifo_w_en !== 1'b1 || grant_id !== 2'd0 || req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL drop_beat2: w_en=%b grant=%0d ready=%b, required 1 0 0001", fifo_w_en, grant_id, req_ready);
    end
    next_cycle();
    req_valid = 4'b1000;
    #1;
    checks++;
    if (fifo_w_en !== 1'b0 || req_ready !== 4'b0000 || locked !== 1'b1) begin
      failures++;
      $display("FAIL drop_bubble: w_en=%b ready=%b locked=%b, required 0 0000 1", fifo_w_en, req_ready, locked);
    end
    next_cycle();
    #1;
    checks++;
    if (fifo_w_en !== 1'b1 || grant_id !== 2'd3 || fifo_data_in !== 8'hA3 || locked !== 1'b0) begin
      failures++;
      $display("FAIL drop_regrant: w_en=%b grant=%0d data=%h locked=%b, required 1 3 a3 0",
               fifo_w_en, grant_id, fifo_data_in, locked);
    end
    next_cycle();
    req_valid = 4'b0000;
    next_cycle();
    #1;
    checks++;
    if (write_count !== 16'd28) begin
      failures++;
      $display("FAIL drop_count: count=%0d, required 28", write_count);
    end
  endtask

  task automatic test_reset_mid_burst();
    req_valid = 4'b0100;
    next_cycle();
    next_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0000 || fifo_w_en !== 1'b0 || fifo_data_in !== 8'h00 || grant_id !== 2'd0 ||
        locked !== 1'b0 || write_count !== 16'd0) begin
      failures++;
      $display("FAIL midrst_async: ready=%b w_en=%b data=%h grant=%0d locked=%b count=%0d, required all zero",
               req_ready, fifo_w_en, fifo_data_in, grant_id, locked, write_count);
    end
    req_valid = 4'b1111;
    next_cycle();
    rst_n = 1'b1;
    #1;
    checks++;
    if (fifo_w_en !== 1'b1 || grant_id !== 2'd0 || write_count !== 16'd0) begin
      failures++;
      $display("FAIL midrst_first: w_en=%b grant=%0d count=%0d, required 1 0 0", fifo_w_en, grant_id, write_count);
    end
    next_cycle();
    #1;
    checks++;
    if (write_count !== 16'd1) begin
      failures++;
      $display("FAIL midrst_count: count=%0d, required 1", write_count);
    end
  endtask

  task automatic test_count_wrap();
    int missed;
    missed = 0;
    rst_n = 1'b0;
    req_valid = 4'b0001;
    next_cycle();
    rst_n = 1'b1;
    for (int n = 0; n < 65537; n++) begin
      #1;
      if (fifo_w_en !== 1'b1) missed++;
      next_cycle();
    end
    req_valid = 4'b0000;
    #1;
    checks++;
    if (missed !== 0) begin
      failures++;
      $display("FAIL wrap_stream: idle cycles=%0d, required 0", missed);
    end
    checks++;
    if (write_count !== 16'd1) begin
      failures++;
      $display("FAIL wrap_count: count=%0d, required 1", write_count);
    end
    checks++;
    if (onehot_bad !== 0) begin
      failures++;
      $display("FAIL ready_onehot: multi-ready cycles=%0d, required 0", onehot_bad);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    onehot_bad = 0;
    test_reset();
    test_round_robin();
    test_single_requester();
    test_full_stall();
    test_owner_drop();
    test_reset_mid_burst();
    test_count_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
